fetch_controller: RTL
=====================

# fetch_controller

Sequences the byte-addressed, combinationally-read instruction memory for the core front end. The block holds the program counter and drives the instruction memory address, capturing the returned big-endian 32-bit word every cycle it has space. Fetched words go into a small prefetch queue, presented to decode with a valid/ready handshake. The block also accepts PC redirects from branch/jump resolution and flushes stale prefetched words.

## Interface
- `ADDRESS_WIDTH`, 32, width of PC, memory address and instruction word
- `RESET_PC`, 0, PC value loaded on reset
- `DEPTH`, 2, prefetch queue entries; power of two, ≥2
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `fetch_en` in 1: permits new fetches when high
- `mem_addr` out ADDRESS_WIDTH: byte address to instruction memory
- `mem_instr` in ADDRESS_WIDTH: word returned combinationally for `mem_addr`
- `redirect_valid` in 1: load new PC and flush queue
- `redirect_pc` in ADDRESS_WIDTH: redirect target
- `instr_valid` out 1: queue head valid
- `instr` out ADDRESS_WIDTH: queue head instruction
- `instr_pc` out ADDRESS_WIDTH: PC of queue head
- `instr_ready` in 1: decode accepts head this cycle
- `misalign_err` out 1: sticky misaligned-redirect flag (see Configuration)

## Operation
- `mem_addr` = PC register, combinationally.
- Pop: `instr_valid && instr_ready`; head advances.
- Push condition: `fetch_en && !redirect_valid && !halted && (count < DEPTH || pop)`. On push, {`mem_instr`, PC} are written at the tail and PC ← PC + 4.
- PC arithmetic is modulo 2^ADDRESS_WIDTH; 0xFFFFFFFC + 4 wraps to 0.
- Queue full and no pop: no push, PC holds, `mem_addr` stable.
- Redirect (priority over push): queue flushed (count ← 0), PC ← target, no push that cycle. A pop in the redirect cycle still counts as accepted by decode.
- When the queue is empty, `instr_valid` = 0 and `instr`/`instr_pc` read 0. Otherwise they show the head entry.
- Queue order is strictly FIFO. Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- Simultaneous push and pop while full is legal. Count stays DEPTH.
- `fetch_en` low: no pushes. Queue still drains. PC holds.

## Timing
- Reset values: PC = RESET_PC, `mem_addr` = RESET_PC, count = 0, `instr_valid` = 0, `instr` = 0, `instr_pc` = 0, `misalign_err` = 0, halted = 0.
- Reset assertion takes effect immediately, including mid-fetch. Queue contents are discarded.
- Fetch-to-valid latency: 1 cycle. A word pushed on edge N is visible at the head after edge N.
- Throughput: 1 instruction/cycle with `instr_ready` held high.
- Redirect-to-valid latency: 2 cycles.
  - Redirect is sampled at edge N.
  - Target is pushed at edge N+1.
  - `instr_valid` with `instr_pc` = target after edge N+1; `instr_valid` is low between N and N+1.
- All outputs except `mem_addr` are registered. `mem_addr` is a direct register output, with no combinational path from inputs.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` flushes the queue, leaves PC unchanged, and sets `misalign_err` and halted.
  - Both flags are sticky until reset. While halted, no pushes occur.
- Macro undefined:
  - `redirect_pc[1:0]` is forced to 00 when loaded.
  - `misalign_err` is tied 0 and there is no halt state.

## Test plan
- Reset release, ROM words 0x00000013/0x00100093/0x00200113 at 0/4/8, `fetch_en`=1, `instr_ready`=1 → `instr_valid` rises 1 cycle after first edge. `instr_pc` reads 0,4,8 on consecutive cycles with matching words.
- `instr_ready`=0 for 5 cycles, DEPTH=2 → count saturates at 2 and `mem_addr` freezes at 8. On ready=1, words for 0 then 4 drain in order, then 8 follows with no bubble.
- Queue full plus `instr_ready`=1 in the same cycle → one pop and one push, count stays 2, next `instr_pc` = previous +4.
- `redirect_valid`=1, `redirect_pc`=0x100 while 2 entries are queued → next cycle `instr_valid`=0. The cycle after, `instr_pc`=0x100, then 0x104.
- `rst_n` pulsed low asynchronously mid-stream (PC=0x20) → outputs immediately return to reset values. Fetch restarts at RESET_PC.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 0x102 → `misalign_err`=1 next cycle, `instr_valid` stays 0, `mem_addr` unchanged. Without the macro, the same stimulus yields `instr_pc`=0x100.

Source files
------------

// File: rtl/fetch_controller_if.sv
// Front-end fetch bus: instruction memory port, redirect input and the
// decode-facing valid/ready instruction stream.
interface fetch_controller_if #(
  parameter int ADDRESS_WIDTH = 32
);
  logic                     fetch_en;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [ADDRESS_WIDTH-1:0] mem_instr;
  logic                     redirect_valid;
  logic [ADDRESS_WIDTH-1:0] redirect_pc;
  logic                     instr_valid;
  logic [ADDRESS_WIDTH-1:0] instr;
  logic [ADDRESS_WIDTH-1:0] instr_pc;
  logic                     instr_ready;
  logic                     misalign_err;

  modport master (
    input  fetch_en, mem_instr, redirect_valid, redirect_pc, instr_ready,
    output mem_addr, instr_valid, instr, instr_pc, misalign_err
  );

  modport slave (
    output fetch_en, mem_instr, redirect_valid, redirect_pc, instr_ready,
    input  mem_addr, instr_valid, instr, instr_pc, misalign_err
  );
endinterface

// File: rtl/fetch_controller.sv
// Program counter plus prefetch queue feeding decode; optional misaligned
// redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_controller #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter int                       DEPTH         = 2
) (
  input logic                clk,
  input logic                rst_n,
  fetch_controller_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] word;
    logic [ADDRESS_WIDTH-1:0] pc;
  } entry_t;

  logic [ADDRESS_WIDTH-1:0] pc;
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;
  logic [CNT_W-1:0]         count;
  entry_t                   queue_mem [DEPTH];

  logic                     halted;
  logic                     misaligned;
  logic [ADDRESS_WIDTH-1:0] target;
  logic                     pop;
  logic                     push;
  logic                     not_empty;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  assign misaligned = (bus.redirect_pc[1:0] != 2'b00);
  assign target     = bus.redirect_pc;

  // Trap is sticky until reset: once set, fetching stops for good.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (bus.redirect_valid && misaligned) begin
      misalign_q <= 1'b1;
    end
  end

  assign halted           = misalign_q;
  assign bus.misalign_err = misalign_q;
`else
  assign misaligned       = 1'b0;
  assign target           = bus.redirect_pc & ~ADDRESS_WIDTH'(3);
  assign halted           = 1'b0;
  assign bus.misalign_err = 1'b0;
`endif

  assign not_empty = (count != '0);
  assign pop       = not_empty && bus.instr_ready;
  assign push      = bus.fetch_en && !bus.redirect_valid && !halted &&
                     ((count < CNT_W'(DEPTH)) || pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (!misaligned) begin
        pc <= target;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        pc     <= pc + ADDRESS_WIDTH'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: queue storage has no reset; stale entries are never visible because
  // the head outputs are gated by count.
  always_ff @(posedge clk) begin
    if (push) begin
      queue_mem[wr_ptr] <= '{word: bus.mem_instr, pc: pc};
    end
  end

  assign bus.mem_addr    = pc;
  assign bus.instr_valid = not_empty;
  assign bus.instr       = not_empty ? queue_mem[rd_ptr].word : '0;
  assign bus.instr_pc    = not_empty ? queue_mem[rd_ptr].pc   : '0;
endmodule
